// File: rtl/spec_seg_adder_pkg.sv
// Shared types and constants for the segmented speculative adder.
// The optional error statistics counter is enabled by SPEC_SEG_ADDER_ERR_STATS_EN.
package spec_seg_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SPEC = 2'd1,
        FIX  = 2'd2,
        HOLD = 2'd3
    } state_t;

    // Width of the saturating misprediction counter.
    localparam int ERR_CNT_W = 16;

    // Number of segments a WIDTH-bit add is split into.
    function automatic int nseg(input int width, input int seg);
        return width / seg;
    endfunction

endpackage

// File: rtl/seg_carry_predictor.sv
// LA-bit generate/propagate prefix cell.
// It predicts the carry out of a window of bit pairs.
// The carry into the LSB of the window is assumed to be 0.
module seg_carry_predictor #(
    parameter int LA = 2
) (
    input  logic [LA-1:0] g,
    input  logic [LA-1:0] p,
    output logic          pc
);

    // Ripple the G|(P&c) prefix from the window LSB upwards, starting from c=0.
    always_comb begin : prefix
        logic c_v;
        c_v = 1'b0;
        for (int k = 0; k < LA; k++) begin
            c_v = g[k] | (p[k] & c_v);
        end
        pc = c_v;
    end

endmodule

// File: rtl/spec_seg_adder.sv
// Segmented approximate adder with per-segment carry prediction.
// In exact mode, a mispredicted add costs one extra correction cycle.
// Optional feature: define SPEC_SEG_ADDER_ERR_STATS_EN to add the err_count output.
// err_count is a saturating count of results whose prediction missed.
module spec_seg_adder
    import spec_seg_adder_pkg::*;
#(
    parameter int  WIDTH = 16,
    parameter int  SEG   = 4,
    parameter int  LA    = 2,
    localparam int NSEG  = nseg(WIDTH, SEG)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             mode_exact,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic [NSEG-1:0]  err_mask,
    output logic             corrected
`ifdef SPEC_SEG_ADDER_ERR_STATS_EN
    ,
    output logic [ERR_CNT_W-1:0] err_count
`endif
);

    state_t           state_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             cin_r;
    logic             mode_r;

    logic [NSEG-1:0]  pc_s;
    logic [WIDTH-1:0] spec_sum_s;
    logic             spec_cout_s;
    logic [WIDTH-1:0] exact_sum_s;
    logic             exact_cout_s;
    logic [NSEG-1:0]  err_mask_s;

    // Segment 0 always sees the true carry-in.
    assign pc_s[0] = cin_r;

    genvar gi;
    for (gi = 1; gi < NSEG; gi++) begin : g_pred
        seg_carry_predictor #(
            .LA (LA)
        ) u_pred (
            .g  (a_r[gi*SEG-LA +: LA] & b_r[gi*SEG-LA +: LA]),
            .p  (a_r[gi*SEG-LA +: LA] ^ b_r[gi*SEG-LA +: LA]),
            .pc (pc_s[gi])
        );
    end

    // Exact reference result; its bits also reveal the true carry into each segment.
    assign {exact_cout_s, exact_sum_s} = {1'b0, a_r} + {1'b0, b_r} + {{WIDTH{1'b0}}, cin_r};

    // Speculative add: each segment is summed independently with its predicted carry-in.
    always_comb begin : spec_path
        logic [SEG:0] t_v;
        t_v         = {(SEG+1){1'b0}};
        spec_sum_s  = {WIDTH{1'b0}};
        spec_cout_s = 1'b0;
        for (int i = 0; i < NSEG; i++) begin
            t_v = {1'b0, a_r[i*SEG +: SEG]} + {1'b0, b_r[i*SEG +: SEG]}
                + {{SEG{1'b0}}, pc_s[i]};
            spec_sum_s[i*SEG +: SEG] = t_v[SEG-1:0];
            spec_cout_s              = t_v[SEG];
        end
    end

    // Misprediction per segment: the exact carry-in is sum ^ a ^ b at the segment LSB.
    always_comb begin : err_path
        err_mask_s = {NSEG{1'b0}};
        for (int i = 1; i < NSEG; i++) begin
            err_mask_s[i] = pc_s[i] ^ exact_sum_s[i*SEG] ^ a_r[i*SEG] ^ b_r[i*SEG];
        end
    end

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            sum       <= {WIDTH{1'b0}};
            cout      <= 1'b0;
            err_mask  <= {NSEG{1'b0}};
            corrected <= 1'b0;
            a_r       <= {WIDTH{1'b0}};
            b_r       <= {WIDTH{1'b0}};
            cin_r     <= 1'b0;
            mode_r    <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        a_r      <= a;
                        b_r      <= b;
                        cin_r    <= cin;
                        mode_r   <= mode_exact;
                        in_ready <= 1'b0;
                        state_r  <= SPEC;
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                SPEC: begin
                    err_mask <= err_mask_s;
                    if ((err_mask_s == {NSEG{1'b0}}) || !mode_r) begin
                        sum       <= spec_sum_s;
                        cout      <= spec_cout_s;
                        corrected <= 1'b0;
                        out_valid <= 1'b1;
                        state_r   <= HOLD;
                    end else begin
                        state_r <= FIX;
                    end
                end
                FIX: begin
                    sum       <= exact_sum_s;
                    cout      <= exact_cout_s;
                    corrected <= 1'b1;
                    out_valid <= 1'b1;
                    state_r   <= HOLD;
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state_r   <= IDLE;
                    end else begin
                        out_valid <= 1'b1;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state_r   <= IDLE;
                end
            endcase
        end
    end

`ifdef SPEC_SEG_ADDER_ERR_STATS_EN
    // Count delivered results that had any misprediction, saturating at all-ones.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_count <= {ERR_CNT_W{1'b0}};
        end else if ((state_r == HOLD) && out_ready
                     && (err_mask != {NSEG{1'b0}})
                     && (err_count != {ERR_CNT_W{1'b1}})) begin
            err_count <= err_count + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
        end else begin
            err_count <= err_count;
        end
    end
`endif

endmodule

// File: tb/tb_spec_seg_adder.sv
// Directed testbench for spec_seg_adder (WIDTH=16, SEG=4, LA=2).
// Checks the err_count output when SPEC_SEG_ADDER_ERR_STATS_EN is defined.
module tb_spec_seg_adder;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        mode_exact;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
    logic [3:0]  err_mask;
    logic        corrected;
`ifdef SPEC_SEG_ADDER_ERR_STATS_EN
    logic [15:0] err_count;
`endif

    int n_vec;
    int n_miscmp;

    spec_seg_adder #(
        .WIDTH (16),
        .SEG   (4),
        .LA    (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .cin        (cin),
        .mode_exact (mode_exact),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .sum        (sum),
        .cout       (cout),
        .err_mask   (err_mask),
        .corrected  (corrected)
`ifdef SPEC_SEG_ADDER_ERR_STATS_EN
        ,
        .err_count  (err_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check_val({tag, "_in_ready"},  32'(in_ready),  32'd1);
        check_val({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check_val({tag, "_sum"},       32'(sum),       32'd0);
        check_val({tag, "_cout"},      32'(cout),      32'd0);
        check_val({tag, "_err_mask"},  32'(err_mask),  32'd0);
        check_val({tag, "_corrected"}, 32'(corrected), 32'd0);
    endtask

    // Issue one operand set and compare the result.
    // When out_ready is 1, also confirm the return to IDLE.
    task automatic do_txn(input string tag, input logic [15:0] ta, input logic [15:0] tb,
                          input logic tcin, input logic tmode, input logic [15:0] esum,
                          input logic ecout, input logic [3:0] eerr, input logic ecorr,
                          input int elat);
        int lat;
        @(negedge clk);
        check_val({tag, "_rdy"}, 32'(in_ready), 32'd1);
        a          = ta;
        b          = tb;
        cin        = tcin;
        mode_exact = tmode;
        in_valid   = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat      = 1;
        while ((out_valid !== 1'b1) && (lat < 10)) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check_val({tag, "_lat"},  32'(lat),       32'(elat));
        check_val({tag, "_sum"},  32'(sum),       32'(esum));
        check_val({tag, "_cout"}, 32'(cout),      32'(ecout));
        check_val({tag, "_err"},  32'(err_mask),  32'(eerr));
        check_val({tag, "_corr"}, 32'(corrected), 32'(ecorr));
        if (out_ready) begin
            @(posedge clk);
            #1;
            check_val({tag, "_done"}, 32'({out_valid, in_ready}), 32'b01);
        end
    endtask

    initial begin
        n_vec      = 0;
        n_miscmp   = 0;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        a          = 16'h0000;
        b          = 16'h0000;
        cin        = 1'b0;
        mode_exact = 1'b0;
        out_ready  = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_idle_outputs("reset");
`ifdef SPEC_SEG_ADDER_ERR_STATS_EN
        check_val("reset_errcnt", 32'(err_count), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // No misprediction, exact mode
        do_txn("noerr", 16'h1234, 16'h1111, 1'b0, 1'b1, 16'h2345, 1'b0, 4'b0000, 1'b0, 2);

        // Reset while correcting: accept, SPEC->FIX, then reset on the FIX edge
        @(negedge clk);
        a          = 16'h00FF;
        b          = 16'h0001;
        cin        = 1'b0;
        mode_exact = 1'b1;
        in_valid   = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_idle_outputs("rstfix");
`ifdef SPEC_SEG_ADDER_ERR_STATS_EN
        check_val("rstfix_errcnt", 32'(err_count), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_val("rstfix_abort", 32'({out_valid, in_ready}), 32'b01);

        // Mispredictions: speculative and corrected
        do_txn("spec_miss",  16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h00F0, 1'b0, 4'b0110, 1'b0, 2);
        do_txn("exact_miss", 16'h00FF, 16'h0001, 1'b0, 1'b1, 16'h0100, 1'b0, 4'b0110, 1'b1, 3);
        do_txn("ovf_spec",   16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'hFFF0, 1'b0, 4'b1110, 1'b0, 2);
`ifdef SPEC_SEG_ADDER_ERR_STATS_EN
        check_val("errcnt3", 32'(err_count), 32'd3);
`endif
        do_txn("ovf_exact",  16'hFFFF, 16'h0001, 1'b0, 1'b1, 16'h0000, 1'b1, 4'b1110, 1'b1, 3);

        // Carry-in into segment 0, and a correctly predicted carry into segment 2
        do_txn("cin_spec",   16'h000F, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 4'b0010, 1'b0, 2);
        do_txn("cin_exact",  16'h000F, 16'h0000, 1'b1, 1'b1, 16'h0010, 1'b0, 4'b0010, 1'b1, 3);
        do_txn("gen_hit",    16'h00C0, 16'h0040, 1'b0, 1'b0, 16'h0100, 1'b0, 4'b0000, 1'b0, 2);
        do_txn("top_cout",   16'h8000, 16'h8000, 1'b0, 1'b1, 16'h0000, 1'b1, 4'b0000, 1'b0, 2);

        // Backpressure: hold the result while a new in_valid is ignored
        out_ready = 1'b0;
        do_txn("bp", 16'h1234, 16'h1111, 1'b0, 1'b1, 16'h2345, 1'b0, 4'b0000, 1'b0, 2);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            a          = 16'hFFFF;
            b          = 16'h0001;
            mode_exact = 1'b1;
            in_valid   = 1'b1;
            @(posedge clk);
            #1;
            check_val("bp_hold", 32'({out_valid, in_ready, sum}), 32'({1'b1, 1'b0, 16'h2345}));
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check_val("bp_release", 32'({out_valid, in_ready}), 32'b01);
        repeat (3) @(posedge clk);
        #1;
        check_val("bp_no_capture", 32'({out_valid, in_ready, sum}), 32'({1'b0, 1'b1, 16'h2345}));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule
